// File: rtl/ahb2apb_pkg.sv
// Shared types for the AHB-Lite to APB bridge.
//   htrans_e       : AHB transfer type encoding
//   bridge_state_e : bridge FSM states
//   HBURST_* / HSIZE_* : AHB control encodings (not decoded by the bridge)
package ahb2apb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WDATA  = 2'b01,
        ST_SETUP  = 2'b10,
        ST_ACCESS = 2'b11
    } bridge_state_e;

endpackage

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB master bridge. Each NONSEQ/SEQ beat becomes one
// APB SETUP/ACCESS transfer; hready is held low until the completer answers
// or the ACCESS timeout expires.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   haddr, hwdata, hwrite, htrans  : AHB request (hburst/hsize not decoded)
//   hrdata, hready                 : AHB response
//   paddr, pwdata, pwrite, psel, penable, prdata, pready : APB requester
//   timeout_err                    : sticky APB timeout flag
module ahb2apb_bridge
    import ahb2apb_pkg::*;
#(
    parameter int unsigned AHB_DW      = 32,
    parameter int unsigned AHB_AW      = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AHB_AW-1:0] haddr,
    input  logic [AHB_DW-1:0] hwdata,
    output logic [AHB_DW-1:0] hrdata,
    input  logic [2:0]        hburst,
    input  logic [2:0]        hsize,
    input  logic              hwrite,
    input  logic [1:0]        htrans,
    output logic              hready,
    output logic [AHB_AW-1:0] paddr,
    output logic [AHB_DW-1:0] pwdata,
    input  logic [AHB_DW-1:0] prdata,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    input  logic              pready,
    output logic              timeout_err
);

    localparam int unsigned CNT_W   = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned CNT_SAT = (TIMEOUT_CYC == 0) ? 1 : TIMEOUT_CYC;
    localparam int unsigned CNT_TO  = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

    bridge_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hready_q, hready_d;
    logic [AHB_DW-1:0] hrdata_q, hrdata_d;
    logic [AHB_AW-1:0] paddr_q, paddr_d;
    logic [AHB_DW-1:0] pwdata_q, pwdata_d;
    logic              pwrite_q, pwrite_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              terr_q, terr_d;

    htrans_e           ht;
    logic              beat_valid;
    logic              timeout_hit;
    logic [3:0]        unused_ahb_ctrl;

    // Burst type and size are accepted but not acted upon.
    assign unused_ahb_ctrl = {hburst == HBURST_SINGLE, hburst == HBURST_INCR,
                              hsize == HSIZE_BYTE, hsize == HSIZE_WORD};

    assign ht          = htrans_e'(htrans);
    assign beat_valid  = (ht == HT_NONSEQ) || (ht == HT_SEQ);
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(CNT_TO));

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hready_d  = hready_q;
        hrdata_d  = hrdata_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        terr_d    = terr_q;

        case (state_q)
            ST_IDLE: begin
                if (hready_q && beat_valid) begin
                    paddr_d  = haddr;
                    pwrite_d = hwrite;
                    hready_d = 1'b0;
                    if (hwrite) begin
                        state_d = ST_WDATA;
                    end else begin
                        // psel is registered, so raise it on entry to SETUP.
                        psel_d  = 1'b1;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_WDATA: begin
                pwdata_d = hwdata;
                psel_d   = 1'b1;
                state_d  = ST_SETUP;
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    hready_d  = 1'b1;
                    if (!pwrite_q) begin
                        hrdata_d = prdata;
                    end
                    state_d   = ST_IDLE;
                end else if (timeout_hit) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    hready_d  = 1'b1;
                    hrdata_d  = '0;
                    terr_d    = 1'b1;
                    state_d   = ST_IDLE;
                end else if (cnt_q != CNT_W'(CNT_SAT)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hready_q  <= 1'b1;
            hrdata_q  <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hready_q  <= hready_d;
            hrdata_q  <= hrdata_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            terr_q    <= terr_d;
        end
    end

    assign hready      = hready_q;
    assign hrdata      = hrdata_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign pwrite      = pwrite_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed bench for ahb2apb_bridge built with a 4-cycle ACCESS timeout.
module tb_ahb2apb_bridge;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] haddr;
    logic [DW-1:0] hwdata;
    logic [DW-1:0] hrdata;
    logic [2:0]    hburst;
    logic [2:0]    hsize;
    logic          hwrite;
    logic [1:0]    htrans;
    logic          hready;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pwrite;
    logic          psel;
    logic          penable;
    logic          pready;
    logic          timeout_err;

    int total = 0;
    int bad   = 0;

    ahb2apb_bridge #(
        .AHB_DW     (DW),
        .AHB_AW     (AW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .haddr      (haddr),
        .hwdata     (hwdata),
        .hrdata     (hrdata),
        .hburst     (hburst),
        .hsize      (hsize),
        .hwrite     (hwrite),
        .htrans     (htrans),
        .hready     (hready),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pwrite     (pwrite),
        .psel       (psel),
        .penable    (penable),
        .pready     (pready),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one AHB beat from an IDLE/hready=1 sample point and runs it to
    // completion. The completer holds pready low for 'lows' ACCESS cycles.
    // Returns to the caller on the sample where hready is back high.
    task automatic run_xfer(input logic [1:0] ht, input logic [31:0] addr,
                            input logic wr, input logic [31:0] wdata, input int lows,
                            output int nwait, output int npsel, output int npen,
                            output int nunstable, output logic [31:0] first_paddr,
                            output logic done);
        int acc;
        nwait = 0; npsel = 0; npen = 0; nunstable = 0; first_paddr = 32'h0; done = 1'b0;
        acc = 0;
        htrans = ht; haddr = addr; hwrite = wr; hwdata = ~wdata; pready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 0) begin
                htrans = 2'b00; haddr = 32'hDEAD_0000; hwrite = ~wr; hwdata = wdata;
            end else if (i == 1) begin
                hwdata = 32'h5555_0000;
            end
            if (psel) begin
                npsel++;
                if (npsel == 1) first_paddr = paddr;
                if (paddr !== addr || pwrite !== wr || (wr && pwdata !== wdata)) nunstable++;
            end
            if (penable) npen++;
            if (hready) begin
                done = 1'b1;
                pready = 1'b1;
                break;
            end
            nwait++;
            if (psel && penable) begin
                pready = (acc >= lows);
                acc++;
            end else begin
                pready = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; htrans = 2'b00; haddr = '0; hwdata = '0; hwrite = 1'b0;
        hburst = 3'b000; hsize = 3'b010; prdata = '0; pready = 1'b0;
        tick(); tick();
        total++;
        if ({hready, psel, penable, pwrite, timeout_err} !== 5'b10000) begin
            bad++; $display("FAIL reset_ctrl got=%b want=10000", {hready, psel, penable, pwrite, timeout_err});
        end
        total++;
        if (hrdata !== 32'h0) begin bad++; $display("FAIL reset_hrdata got=%h want=0", hrdata); end
        total++;
        if (paddr !== 32'h0) begin bad++; $display("FAIL reset_paddr got=%h want=0", paddr); end
        total++;
        if (pwdata !== 32'h0) begin bad++; $display("FAIL reset_pwdata got=%h want=0", pwdata); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        int nw, np, ne, nu; logic [31:0] fa; logic dn;
        prdata = 32'hCAFE_0001;
        run_xfer(2'b10, 32'h0000_0040, 1'b0, 32'h0, 0, nw, np, ne, nu, fa, dn);
        total++;
        if (dn !== 1'b1) begin bad++; $display("FAIL rd_done got=%b want=1", dn); end
        total++;
        if (nw != 2) begin bad++; $display("FAIL rd_waits got=%0d want=2", nw); end
        total++;
        if (np != 2 || ne != 1) begin bad++; $display("FAIL rd_psel_pen got=%0d/%0d want=2/1", np, ne); end
        total++;
        if (nu != 0 || fa !== 32'h40) begin bad++; $display("FAIL rd_addr got=%h unstable=%0d want=40/0", fa, nu); end
        total++;
        if (hrdata !== 32'hCAFE_0001) begin bad++; $display("FAIL rd_data got=%h want=cafe0001", hrdata); end
    endtask

    task automatic test_single_write();
        int nw, np, ne, nu; logic [31:0] fa; logic dn;
        prdata = 32'hFFFF_FFFF;
        run_xfer(2'b10, 32'h0000_0010, 1'b1, 32'hA5A5_5A5A, 0, nw, np, ne, nu, fa, dn);
        total++;
        if (dn !== 1'b1 || nw != 3) begin bad++; $display("FAIL wr_waits got=%0d done=%b want=3", nw, dn); end
        total++;
        if (np != 2 || ne != 1) begin bad++; $display("FAIL wr_psel_pen got=%0d/%0d want=2/1", np, ne); end
        total++;
        if (nu != 0 || fa !== 32'h10) begin bad++; $display("FAIL wr_stable got=%h unstable=%0d want=10/0", fa, nu); end
        total++;
        if (pwdata !== 32'hA5A5_5A5A) begin bad++; $display("FAIL wr_pwdata got=%h want=a5a55a5a", pwdata); end
        total++;
        if (hrdata !== 32'hCAFE_0001) begin bad++; $display("FAIL wr_hrdata_kept got=%h want=cafe0001", hrdata); end
    endtask

    task automatic test_wait_states();
        int nw, np, ne, nu; logic [31:0] fa; logic dn;
        prdata = 32'h0000_BEEF;
        run_xfer(2'b10, 32'h0000_0080, 1'b0, 32'h0, 3, nw, np, ne, nu, fa, dn);
        total++;
        if (dn !== 1'b1 || nw != 5) begin bad++; $display("FAIL ws_waits got=%0d done=%b want=5", nw, dn); end
        total++;
        if (np != 5 || ne != 4 || nu != 0) begin
            bad++; $display("FAIL ws_psel got=%0d/%0d unstable=%0d want=5/4/0", np, ne, nu);
        end
        total++;
        if (hrdata !== 32'h0000_BEEF) begin bad++; $display("FAIL ws_data got=%h want=0000beef", hrdata); end
        total++;
        if (timeout_err !== 1'b0) begin bad++; $display("FAIL ws_terr got=%b want=0", timeout_err); end
    endtask

    task automatic test_back_to_back();
        int nw, np, ne, nu; logic [31:0] fa; logic dn;
        prdata = 32'h3333_4444;
        run_xfer(2'b10, 32'h0000_0020, 1'b1, 32'h1111_2222, 0, nw, np, ne, nu, fa, dn);
        total++;
        if (dn !== 1'b1 || nw != 3 || fa !== 32'h20 || nu != 0) begin
            bad++; $display("FAIL b2b_first got=%h waits=%0d want=20/3", fa, nw);
        end
        total++;
        if (pwdata !== 32'h1111_2222) begin bad++; $display("FAIL b2b_pwdata got=%h want=11112222", pwdata); end
        run_xfer(2'b11, 32'h0000_0024, 1'b0, 32'h0, 0, nw, np, ne, nu, fa, dn);
        total++;
        if (dn !== 1'b1 || nw != 2) begin bad++; $display("FAIL b2b_no_dead got=%0d want=2", nw); end
        total++;
        if (fa !== 32'h24 || nu != 0) begin bad++; $display("FAIL b2b_second got=%h want=24", fa); end
        total++;
        if (hrdata !== 32'h3333_4444) begin bad++; $display("FAIL b2b_data got=%h want=33334444", hrdata); end
    endtask

    task automatic test_timeout();
        int nw, np, ne, nu; logic [31:0] fa; logic dn;
        prdata = 32'h1234_5678;
        run_xfer(2'b10, 32'h0000_0030, 1'b0, 32'h0, 100, nw, np, ne, nu, fa, dn);
        total++;
        if (dn !== 1'b1 || nw != 5) begin bad++; $display("FAIL to_waits got=%0d done=%b want=5", nw, dn); end
        total++;
        if (np != 5 || ne != 4) begin bad++; $display("FAIL to_access got=%0d/%0d want=5/4", np, ne); end
        total++;
        if (hrdata !== 32'h0) begin bad++; $display("FAIL to_hrdata got=%h want=0", hrdata); end
        total++;
        if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_flag got=%b want=1", timeout_err); end
        prdata = 32'h0000_0077;
        run_xfer(2'b10, 32'h0000_0034, 1'b0, 32'h0, 0, nw, np, ne, nu, fa, dn);
        total++;
        if (dn !== 1'b1 || nw != 2 || hrdata !== 32'h77) begin
            bad++; $display("FAIL to_recover got=%h waits=%0d want=77/2", hrdata, nw);
        end
        total++;
        if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b want=1", timeout_err); end
    endtask

    task automatic test_reset_and_idle();
        int nw, np, ne, nu; logic [31:0] fa; logic dn;
        int busy_hits;
        htrans = 2'b10; haddr = 32'h0000_0050; hwrite = 1'b0; pready = 1'b0;
        tick();
        htrans = 2'b00;
        tick();
        total++;
        if (penable !== 1'b1) begin bad++; $display("FAIL rst_in_access got=%b want=1", penable); end
        reset = 1'b1;
        tick();
        total++;
        if ({psel, penable, hready} !== 3'b001) begin
            bad++; $display("FAIL rst_mid got=%b want=001", {psel, penable, hready});
        end
        total++;
        if (timeout_err !== 1'b0 || paddr !== 32'h0) begin
            bad++; $display("FAIL rst_mid_regs got=%b/%h want=0/0", timeout_err, paddr);
        end
        reset = 1'b0; pready = 1'b1;
        busy_hits = 0;
        for (int i = 0; i < 6; i++) begin
            htrans = (i % 2 == 0) ? 2'b01 : 2'b00;
            haddr  = 32'h0000_0100 + 32'(i * 4);
            hwrite = i[0];
            tick();
            if (psel || !hready) busy_hits++;
        end
        htrans = 2'b00;
        total++;
        if (busy_hits != 0) begin bad++; $display("FAIL idle_busy got=%0d want=0", busy_hits); end
        prdata = 32'h0000_0099;
        run_xfer(2'b10, 32'h0000_0060, 1'b0, 32'h0, 0, nw, np, ne, nu, fa, dn);
        total++;
        if (dn !== 1'b1 || nw != 2 || hrdata !== 32'h99) begin
            bad++; $display("FAIL post_rst_read got=%h waits=%0d want=99/2", hrdata, nw);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_wait_states();
        test_back_to_back();
        test_timeout();
        test_reset_and_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb2apb_bridge.md
Name: ahb2apb_bridge

Overview:
- RTL AHB-Lite-slave-to-APB-master bridge. It sits directly downstream of the AHB master agent's interface (haddr/hwdata/hrdata/hburst/hsize/hwrite/hready/htrans) and drives a single APB completer.
- Each valid AHB beat becomes one APB SETUP/ACCESS transfer. AHB wait states are inserted via hready until the APB side completes.
- A programmable timeout counter prevents a hung APB completer from stalling the AHB bus.

Parameters:
- AHB_DW, 32, AHB/APB data width in bits (32 only supported).
- AHB_AW, 32, AHB/APB address width in bits.
- TIMEOUT_CYC, 16, maximum ACCESS cycles waiting for pready; 0 disables the timeout.

Ports:
- clk  input  1  bridge clock, shared by AHB and APB.
- reset  input  1  synchronous, active-high reset.
- haddr  input  AHB_AW  AHB address.
- hwdata  input  AHB_DW  AHB write data; valid in the data phase.
- hrdata  output  AHB_DW  AHB read data.
- hburst  input  3  burst type; ignored, every beat is handled individually.
- hsize  input  3  transfer size; full-width only, not decoded.
- hwrite  input  1  1 = write.
- htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hready  output  1  transfer done / bridge ready.
- paddr  output  AHB_AW  APB address.
- pwdata  output  AHB_DW  APB write data.
- prdata  input  AHB_DW  APB read data.
- pwrite  output  1  APB direction.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pready  input  1  APB completer ready.
- timeout_err  output  1  sticky flag; set on any APB timeout, cleared only by reset.

Behaviour:
- All outputs are registered. Reset values: hready=1, hrdata=0, paddr=0, pwdata=0, pwrite=0, psel=0, penable=0, timeout_err=0, state=IDLE, timeout counter=0.
- A valid transfer is accepted when state==IDLE, hready==1 and htrans[1]==1 (NONSEQ or SEQ). IDLE and BUSY beats are ignored with no APB activity.
- FSM states: IDLE, WDATA, SETUP, ACCESS.
- IDLE: on acceptance, latch paddr<=haddr and pwrite<=hwrite, and drive hready<=0. Go to WDATA if hwrite=1, else to SETUP.
- WDATA: latch pwdata<=hwdata (the AHB data phase). Go to SETUP.
- SETUP: psel=1, penable=0. Clear the timeout counter. Go to ACCESS.
- ACCESS: psel=1, penable=1; the counter increments each cycle pready==0.
  - pready==1: psel<=0, penable<=0, hready<=1, hrdata<=prdata (reads only; writes leave hrdata unchanged). Go to IDLE.
  - TIMEOUT_CYC!=0 and counter reaches TIMEOUT_CYC-1 with pready==0: same exit, but hrdata<=0 and timeout_err<=1.
- Latency, with pready high on the first ACCESS cycle: reads have 2 AHB wait states, writes have 3.
- Back-to-back: the IDLE cycle with hready=1 is the completed data phase and also samples the next address phase. No dead cycle is required beyond this.
- psel and paddr stay stable from SETUP through the end of ACCESS. pwdata stays stable for the whole APB write.
- Timeout counter width is $clog2(TIMEOUT_CYC+1). It never wraps; it saturates at its terminal count.
- Reset mid-transfer: the next edge forces IDLE and the reset values, dropping psel/penable immediately. The in-flight transfer is abandoned.
- pready sampled outside ACCESS is ignored.

Decomposition:
- Package ahb2apb_pkg holds:
  - htrans_e {HT_IDLE, HT_BUSY, HT_NONSEQ, HT_SEQ};
  - hburst/hsize encodings as localparams;
  - bridge_state_e {ST_IDLE, ST_WDATA, ST_SETUP, ST_ACCESS}.
- Single module; the timeout counter is too small to justify a sub-module.

Test Plan:
- Single read: htrans=10, hwrite=0, haddr=0x0000_0040; completer returns pready=1 on the first ACCESS with prdata=0xCAFE_0001 -> psel high 2 cycles (penable high in the 2nd), hready low 2 cycles, hrdata=0xCAFE_0001 when hready rises.
- Single write: haddr=0x10, hwdata=0xA5A5_5A5A -> pwrite=1, pwdata=0xA5A5_5A5A throughout SETUP and ACCESS, 3 wait states, hrdata unchanged.
- Wait states: read with pready held low for 3 ACCESS cycles -> hready low 5 cycles; paddr/psel stable throughout; timeout_err stays 0.
- Back-to-back NONSEQ write then SEQ read (addr 0x20, 0x24) -> two distinct APB transfers in order, with second address accepted on the cycle the first hready returns high.
- Timeout: TIMEOUT_CYC=4, pready tied 0 on a read -> exit after 4 ACCESS cycles, hrdata=0, timeout_err=1 and still 1 after a later good transfer.
- Reset during ACCESS, plus htrans=BUSY/IDLE stimulus -> psel/penable=0 and hready=1 on the next edge; BUSY/IDLE beats never assert psel.
